// File: rtl/register_file_pkg.sv
//==============================================================================
// Module      : register_file_pkg
// Description : Shared definitions for the architectural register file, the
//               reorder buffer and the decoder: register count, ROB-id width,
//               the ROB-id type and the hard-wired zero register id.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package register_file_pkg;

    localparam int NUM_REGS = 32;
    localparam int ROB_ID_W = 5;
    localparam int REG_ID_W = 5;
    localparam int XLEN     = 32;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam reg_id_t REG_ZERO = '0;

    // x0 is never written, never busy and always reads as zero.
    function automatic logic is_reg_zero(input reg_id_t id);
        return (id == REG_ZERO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
//==============================================================================
// Module      : rf_read_port
// Description : One combinational operand read port of the register file.
//               Takes the registered busy/tag/value of the addressed register,
//               forces x0 to "ready, zero", and (when the build macro
//               REGFILE_COMMIT_BYPASS_EN is defined) forwards a same-cycle
//               commit that retires the pending tag of the addressed register.
// Ports       : i_rd_id            read address
//               i_st_busy/tag/value registered state of register i_rd_id
//               i_cm_*             same-cycle commit (bypass build only)
//               o_busy/o_tag/o_value operand lookup result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_read_port
    import register_file_pkg::*;
(
    input  logic [REG_ID_W-1:0] i_rd_id,
    input  logic                i_st_busy,
    input  logic [ROB_ID_W-1:0] i_st_tag,
    input  logic [XLEN-1:0]     i_st_value,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic                i_cm_valid,
    input  logic [REG_ID_W-1:0] i_cm_reg_id,
    input  logic [ROB_ID_W-1:0] i_cm_rob_id,
    input  logic [XLEN-1:0]     i_cm_value,
`endif
    output logic                o_busy,
    output logic [ROB_ID_W-1:0] o_tag,
    output logic [XLEN-1:0]     o_value
);

    logic                w_busy;
    logic [ROB_ID_W-1:0] w_tag;
    logic [XLEN-1:0]     w_value;

    always_comb begin
        w_busy  = i_st_busy;
        w_tag   = i_st_tag;
        w_value = i_st_value;
`ifdef REGFILE_COMMIT_BYPASS_EN
        // Only a commit that retires the current owner of the register may be
        // forwarded; a stale commit (older tag) leaves the register pending.
        if (i_cm_valid && (i_cm_reg_id == i_rd_id) && i_st_busy &&
            (i_st_tag == i_cm_rob_id)) begin
            w_busy  = 1'b0;
            w_value = i_cm_value;
        end
`endif
        if (is_reg_zero(i_rd_id)) begin
            w_busy  = 1'b0;
            w_tag   = '0;
            w_value = '0;
        end
    end

    assign o_busy  = w_busy;
    assign o_tag   = w_tag;
    assign o_value = w_value;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
//==============================================================================
// Module      : register_file
// Description : 32 x 32-bit architectural register file with per-register
//               busy bit and ROB-id rename tag. Launch marks a destination as
//               pending on a ROB entry, commit writes the value and clears the
//               pending state if the committing entry still owns the register.
//               Two combinational read ports serve the decoder.
//               Optional build macro: REGFILE_COMMIT_BYPASS_EN (same-cycle
//               commit forwarding on the read ports).
// Ports       : clk_in, rst_in (async, active-low), rdy_in (global enable)
//               _clear (flush busy bits), _stall (blocks launch)
//               _rf_launch_*  rename-launch request
//               _rf_commit_*  commit write-back
//               _rs1_*/_rs2_* operand read ports
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module register_file
    import register_file_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _stall,
    input  logic                _rf_launch_ready,
    input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
    input  logic [REG_ID_W-1:0] _rf_launch_register_id,
    input  logic                _rf_commit_ready,
    input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
    input  logic [REG_ID_W-1:0] _rf_commit_register_id,
    input  logic [XLEN-1:0]     _rf_commit_value,
    input  logic [REG_ID_W-1:0] _rs1_id,
    input  logic [REG_ID_W-1:0] _rs2_id,
    output logic                _rs1_busy,
    output logic                _rs2_busy,
    output logic [ROB_ID_W-1:0] _rs1_tag,
    output logic [ROB_ID_W-1:0] _rs2_tag,
    output logic [XLEN-1:0]     _rs1_value,
    output logic [XLEN-1:0]     _rs2_value
);

    logic [XLEN-1:0]     r_value [NUM_REGS];
    logic [ROB_ID_W-1:0] r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic w_commit_valid;
    logic w_launch_valid;
    logic w_commit_match;

    // rdy_in gates every update, so it is folded into both strobes; the
    // bypass therefore never forwards a commit that will not take effect.
    assign w_commit_valid = rdy_in && _rf_commit_ready &&
                            !is_reg_zero(_rf_commit_register_id);
    assign w_launch_valid = rdy_in && _rf_launch_ready && !_stall && !_clear &&
                            !is_reg_zero(_rf_launch_register_id);

    // Commit only releases the register if it is still the youngest owner.
    assign w_commit_match = r_busy[_rf_commit_register_id] &&
                            (r_tag[_rf_commit_register_id] == _rf_commit_rob_id);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else begin
            if (_clear && rdy_in) begin
                r_busy <= '0;
            end
            if (w_commit_valid) begin
                r_value[_rf_commit_register_id] <= _rf_commit_value;
                if (w_commit_match) begin
                    r_busy[_rf_commit_register_id] <= 1'b0;
                end
            end
            // Placed last so a same-register launch overrides the commit's
            // busy release: the new owner is younger than the committer.
            if (w_launch_valid) begin
                r_busy[_rf_launch_register_id] <= 1'b1;
                r_tag[_rf_launch_register_id]  <= _rf_launch_rob_id;
            end
        end
    end

    rf_read_port u_rs1_port (
        .i_rd_id     (_rs1_id),
        .i_st_busy   (r_busy[_rs1_id]),
        .i_st_tag    (r_tag[_rs1_id]),
        .i_st_value  (r_value[_rs1_id]),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .i_cm_valid  (w_commit_valid),
        .i_cm_reg_id (_rf_commit_register_id),
        .i_cm_rob_id (_rf_commit_rob_id),
        .i_cm_value  (_rf_commit_value),
`endif
        .o_busy      (_rs1_busy),
        .o_tag       (_rs1_tag),
        .o_value     (_rs1_value)
    );

    rf_read_port u_rs2_port (
        .i_rd_id     (_rs2_id),
        .i_st_busy   (r_busy[_rs2_id]),
        .i_st_tag    (r_tag[_rs2_id]),
        .i_st_value  (r_value[_rs2_id]),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .i_cm_valid  (w_commit_valid),
        .i_cm_reg_id (_rf_commit_register_id),
        .i_cm_rob_id (_rf_commit_rob_id),
        .i_cm_value  (_rf_commit_value),
`endif
        .o_busy      (_rs2_busy),
        .o_tag       (_rs2_tag),
        .o_value     (_rs2_value)
    );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
//==============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. Directed scenarios
//               plus randomized traffic checked against an array-based model
//               of the architectural state (value / busy / tag per register).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        clear;
    logic        stall;
    logic        l_rdy;
    logic [4:0]  l_rob;
    logic [4:0]  l_id;
    logic        c_rdy;
    logic [4:0]  c_rob;
    logic [4:0]  c_id;
    logic [31:0] c_val;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference architectural state.
    logic [31:0] m_value [32];
    logic        m_busy  [32];
    logic [4:0]  m_tag   [32];

    register_file dut (
        .clk_in                 (clk),
        .rst_in                 (rst_n),
        .rdy_in                 (rdy),
        ._clear                 (clear),
        ._stall                 (stall),
        ._rf_launch_ready       (l_rdy),
        ._rf_launch_rob_id      (l_rob),
        ._rf_launch_register_id (l_id),
        ._rf_commit_ready       (c_rdy),
        ._rf_commit_rob_id      (c_rob),
        ._rf_commit_register_id (c_id),
        ._rf_commit_value       (c_val),
        ._rs1_id                (rs1_id),
        ._rs2_id                (rs2_id),
        ._rs1_busy              (rs1_busy),
        ._rs2_busy              (rs2_busy),
        ._rs1_tag               (rs1_tag),
        ._rs2_tag               (rs2_tag),
        ._rs1_value             (rs1_value),
        ._rs2_value             (rs2_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_value[i] = '0;
            m_busy[i]  = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    // Architectural effect of one clock edge, from the current bench inputs.
    task automatic model_step();
        bit c_ok;
        bit l_ok;
        bit owner;
        if (!rdy) return;
        c_ok  = c_rdy && (c_id != 0);
        l_ok  = l_rdy && !stall && !clear && (l_id != 0);
        owner = c_ok && m_busy[c_id] && (m_tag[c_id] == c_rob);
        if (c_ok) m_value[c_id] = c_val;
        if (clear) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        if (owner) m_busy[c_id] = 1'b0;
        if (l_ok) begin
            m_busy[l_id] = 1'b1;
            m_tag[l_id]  = l_rob;
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clear = 1'b0; stall = 1'b0;
        l_rdy = 1'b0; l_rob = '0; l_id = '0;
        c_rdy = 1'b0; c_rob = '0; c_id = '0; c_val = '0;
    endtask

    task automatic drive_cycle(input logic lv, input logic [4:0] lrob, input logic [4:0] lid,
                               input logic cv, input logic [4:0] crob, input logic [4:0] cid,
                               input logic [31:0] cval, input logic clr, input logic stl,
                               input logic rd);
        l_rdy = lv; l_rob = lrob; l_id = lid;
        c_rdy = cv; c_rob = crob; c_id = cid; c_val = cval;
        clear = clr; stall = stl; rdy = rd;
        @(posedge clk);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rs1_id = 5'd5; rs2_id = 5'd0;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h0 || rs1_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_x5: busy=%0b tag=%0d value=%h, expected busy=0 tag=0 value=0",
                     rs1_busy, rs1_tag, rs1_value);
        end
        n_tests++;
        if (rs2_busy !== 1'b0 || rs2_value !== 32'h0 || rs2_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_x0: busy=%0b tag=%0d value=%h, expected all 0",
                     rs2_busy, rs2_tag, rs2_value);
        end
    endtask

    task automatic test_launch_commit();
        drive_cycle(1, 5'd3, 5'd5, 0, 0, 0, 0, 0, 0, 1);
        rs1_id = 5'd5; #1;
        n_tests++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL launch_x5: busy=%0b tag=%0d, expected busy=1 tag=3", rs1_busy, rs1_tag);
        end
        drive_cycle(0, 0, 0, 1, 5'd3, 5'd5, 32'hDEADBEEF, 0, 0, 1);
        rs1_id = 5'd5; #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL commit_x5: busy=%0b value=%h, expected busy=0 value=deadbeef",
                     rs1_busy, rs1_value);
        end
    endtask

    task automatic test_stale_commit();
        drive_cycle(1, 5'd2, 5'd7, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 5'd9, 5'd7, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1, 5'd2, 5'd7, 32'h11, 0, 0, 1);
        rs2_id = 5'd7; #1;
        n_tests++;
        if (rs2_value !== 32'h11 || rs2_busy !== 1'b1 || rs2_tag !== 5'd9) begin
            n_fail++;
            $display("FAIL stale_commit_x7: busy=%0b tag=%0d value=%h, expected busy=1 tag=9 value=11",
                     rs2_busy, rs2_tag, rs2_value);
        end
    endtask

    task automatic test_same_cycle();
        drive_cycle(1, 5'd6, 5'd4, 1, 5'd1, 5'd4, 32'h22, 0, 0, 1);
        rs1_id = 5'd4; #1;
        n_tests++;
        if (rs1_value !== 32'h22 || rs1_busy !== 1'b1 || rs1_tag !== 5'd6) begin
            n_fail++;
            $display("FAIL same_cycle_x4: busy=%0b tag=%0d value=%h, expected busy=1 tag=6 value=22",
                     rs1_busy, rs1_tag, rs1_value);
        end
        // Matching tag in the same cycle: launch still wins.
        drive_cycle(1, 5'd8, 5'd4, 1, 5'd6, 5'd4, 32'h44, 0, 0, 1);
        rs1_id = 5'd4; #1;
        n_tests++;
        if (rs1_value !== 32'h44 || rs1_busy !== 1'b1 || rs1_tag !== 5'd8) begin
            n_fail++;
            $display("FAIL same_cycle_match_x4: busy=%0b tag=%0d value=%h, expected busy=1 tag=8 value=44",
                     rs1_busy, rs1_tag, rs1_value);
        end
    endtask

    task automatic test_clear();
        drive_cycle(1, 5'd10, 5'd1, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 5'd11, 5'd2, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 5'd12, 5'd3, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 5'd4, 5'd8, 1, 5'd11, 5'd2, 32'h33, 1, 0, 1);
        for (int r = 1; r <= 8; r++) begin
            rs1_id = r[4:0]; #1;
            n_tests++;
            if (rs1_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_busy_x%0d: busy=%0b, expected 0", r, rs1_busy);
            end
        end
        rs2_id = 5'd2; #1;
        n_tests++;
        if (rs2_value !== 32'h33) begin
            n_fail++;
            $display("FAIL clear_commit_x2: value=%h, expected 33", rs2_value);
        end
    endtask

    task automatic test_x0_and_rdy();
        drive_cycle(1, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1, 5'd7, 5'd0, 32'd5, 0, 0, 1);
        drive_cycle(1, 5'd13, 5'd9, 1, 5'd1, 5'd9, 32'h99, 1, 0, 0);
        rs1_id = 5'd0; rs2_id = 5'd9; #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_write: busy=%0b value=%h, expected busy=0 value=0", rs1_busy, rs1_value);
        end
        n_tests++;
        if (rs2_busy !== 1'b0 || rs2_value !== 32'h0) begin
            n_fail++;
            $display("FAIL rdy_low_x9: busy=%0b value=%h, expected busy=0 value=0", rs2_busy, rs2_value);
        end
        // Stall blocks launch only; commit still lands.
        drive_cycle(1, 5'd14, 5'd9, 1, 5'd2, 5'd9, 32'h77, 0, 1, 1);
        rs2_id = 5'd9; #1;
        n_tests++;
        if (rs2_busy !== 1'b0 || rs2_value !== 32'h77) begin
            n_fail++;
            $display("FAIL stall_x9: busy=%0b value=%h, expected busy=0 value=77", rs2_busy, rs2_value);
        end
    endtask

    task automatic test_bypass();
        drive_cycle(1, 5'd3, 5'd5, 0, 0, 0, 0, 0, 0, 1);
        c_rdy = 1'b1; c_rob = 5'd3; c_id = 5'd5; c_val = 32'hCAFEF00D;
        rs1_id = 5'd5; #1;
        n_tests++;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (rs1_busy !== 1'b0 || rs1_value !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL bypass_x5: busy=%0b value=%h, expected busy=0 value=cafef00d",
                     rs1_busy, rs1_value);
        end
`else
        if (rs1_busy !== 1'b1 || rs1_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL no_bypass_x5: busy=%0b tag=%0d, expected busy=1 tag=3", rs1_busy, rs1_tag);
        end
`endif
        @(posedge clk);
        model_step();
        #1;
        idle_inputs();
        rs1_id = 5'd5; #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL commit_after_x5: busy=%0b value=%h, expected busy=0 value=cafef00d",
                     rs1_busy, rs1_value);
        end
    endtask

    task automatic test_random();
        logic        exp_busy;
        logic [31:0] exp_value;
        for (int n = 0; n < 300; n++) begin
            l_rdy = 1'($urandom_range(0, 1));
            l_rob = 5'($urandom);
            l_id  = 5'($urandom_range(0, 7));
            c_rdy = 1'($urandom_range(0, 1));
            c_id  = 5'($urandom_range(0, 7));
            c_rob = ($urandom_range(0, 1) == 1) ? m_tag[c_id] : 5'($urandom);
            c_val = $urandom;
            clear = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 7) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            rs1_id = 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 7));
            #1;
            // Pre-edge read: registered state, plus forwarding in the bypass build.
            exp_busy  = m_busy[rs1_id];
            exp_value = m_value[rs1_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (rdy && c_rdy && c_id != 0 && c_id == rs1_id && m_busy[rs1_id] &&
                m_tag[rs1_id] == c_rob) begin
                exp_busy  = 1'b0;
                exp_value = c_val;
            end
`endif
            n_tests++;
            if (rs1_busy !== exp_busy || (!exp_busy && rs1_value !== exp_value) ||
                (exp_busy && rs1_tag !== m_tag[rs1_id])) begin
                n_fail++;
                $display("FAIL rand_pre_rs1 it=%0d x%0d: busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                         n, rs1_id, rs1_busy, rs1_tag, rs1_value, exp_busy, m_tag[rs1_id], exp_value);
            end
            @(posedge clk);
            model_step();
            #1;
            idle_inputs();
            #1;
            n_tests++;
            if (rs1_busy !== m_busy[rs1_id] || (!m_busy[rs1_id] && rs1_value !== m_value[rs1_id]) ||
                (m_busy[rs1_id] && rs1_tag !== m_tag[rs1_id])) begin
                n_fail++;
                $display("FAIL rand_rs1 it=%0d x%0d: busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                         n, rs1_id, rs1_busy, rs1_tag, rs1_value, m_busy[rs1_id], m_tag[rs1_id], m_value[rs1_id]);
            end
            n_tests++;
            if (rs2_busy !== m_busy[rs2_id] || (!m_busy[rs2_id] && rs2_value !== m_value[rs2_id]) ||
                (m_busy[rs2_id] && rs2_tag !== m_tag[rs2_id])) begin
                n_fail++;
                $display("FAIL rand_rs2 it=%0d x%0d: busy=%0b tag=%0d value=%h, expected busy=%0b tag=%0d value=%h",
                         n, rs2_id, rs2_busy, rs2_tag, rs2_value, m_busy[rs2_id], m_tag[rs2_id], m_value[rs2_id]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1, 5'd7, 5'd12, 1, 5'd0, 5'd13, 32'h1234, 0, 0, 1);
        // Drop reset mid-cycle while a launch and commit are presented.
        l_rdy = 1'b1; l_rob = 5'd5; l_id = 5'd14;
        c_rdy = 1'b1; c_id = 5'd13; c_val = 32'h5678;
        #2 rst_n = 1'b0;
        model_reset();
        rs1_id = 5'd12; rs2_id = 5'd13; #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs2_value !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: x12 busy=%0b x13 value=%h, expected busy=0 value=0",
                     rs1_busy, rs2_value);
        end
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b1;
        rs1_id = 5'd14; #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rs2_value !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_held: x14 busy=%0b x13 value=%h, expected busy=0 value=0",
                     rs1_busy, rs2_value);
        end
    endtask

    initial begin
        rs1_id = '0;
        rs2_id = '0;
        test_reset();
        test_launch_commit();
        test_stale_commit();
        test_same_cycle();
        test_clear();
        test_x0_and_rdy();
        test_bypass();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's launch and commit outputs and upstream of the decoder's operand lookup. Holds 32 × 32-bit values plus a busy bit and a ROB-id tag per register. Launch marks a destination register as pending on a ROB entry. Commit writes the value and clears the tag when it is still current. Two combinational read ports give the decoder either a ready value or the ROB id to query.

## Interface
- `NUM_REGS`, 32, register count; x0 is hard-wired to zero.
- `ROB_ID_W`, 5, ROB-id tag width.
- `clk_in`  in  1  system clock, rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  when low, no state changes.
- `_clear`  in  1  flush after a mispredict; all busy bits cleared.
- `_stall`  in  1  suppresses launch only.
- `_rf_launch_ready`  in  1  launch strobe.
- `_rf_launch_rob_id`  in  ROB_ID_W  tag to install.
- `_rf_launch_register_id`  in  5  destination register.
- `_rf_commit_ready`  in  1  commit strobe.
- `_rf_commit_rob_id`  in  ROB_ID_W  committing entry.
- `_rf_commit_register_id`  in  5  committed register.
- `_rf_commit_value`  in  32  committed value.
- `_rs1_id`, `_rs2_id`  in  5 each  read addresses.
- `_rs1_busy`, `_rs2_busy`  out  1 each  the register is awaiting a ROB result.
- `_rs1_tag`, `_rs2_tag`  out  ROB_ID_W each  pending ROB id; valid only when busy.
- `_rs1_value`, `_rs2_value`  out  32 each  architectural value; valid only when not busy.

## Operation
- State: `value[32]`, `busy[32]`, `tag[32]`. All state updates on the rising edge, and only when `rdy_in`=1.
- Commit with `_rf_commit_ready`=1 and register id ≠ 0:
  - `value[rd]` ← commit value.
  - If `busy[rd]` is set and `tag[rd]` equals the commit ROB id, `busy[rd]` ← 0.
  - Otherwise the busy bit and tag are untouched, because a younger launch owns the register.
- Launch with `_rf_launch_ready`=1, `_stall`=0, `_clear`=0 and register id ≠ 0: `busy[rd]` ← 1 and `tag[rd]` ← launch ROB id.
- Launch and commit to the same register in the same cycle:
  - The commit value is written.
  - The launch tag is installed and busy ends at 1, so launch wins regardless of tag match.
- `_clear`=1:
  - Every `busy` bit ← 0 and tags become don't-care.
  - The launch is ignored.
  - A commit in the same cycle still writes its value. The committing instruction is the mispredicted branch itself or older.
- x0 is never written and never busy. Reads of x0 return value 0 and busy 0.
- Read ports are purely combinational from the current state, apart from the bypass described under Configuration.

## Timing
- Reset (`rst_in`=0, asynchronous) sets all values to 0, all busy bits to 0 and all tags to 0.
- Outputs after reset: busy 0, tag 0, value 0 on every port.
- Read latency is 0 cycles (combinational).
- Write visibility is the next cycle: a launch in cycle N shows busy=1 from cycle N+1.
- Reset may be asserted mid-operation; the asynchronous clear overrides any in-flight write.
- With `rdy_in`=0, launch, commit and clear are all ignored in that cycle. Inputs are not latched.

## Configuration
- Macro `REGFILE_COMMIT_BYPASS_EN`.
- When defined, a read port whose address matches a same-cycle valid commit, with `busy`=1 and `tag` equal to the commit ROB id, returns busy=0 and the commit value combinationally. This saves the decoder one cycle.
- When undefined, reads reflect registered state only, and the commit becomes visible in cycle N+1.

## Structure
- Shared package holds the following, also used by the reorder buffer and decoder:
  - `NUM_REGS` and `ROB_ID_W`.
  - Typedef `rob_id_t`.
  - Constant `REG_ZERO`=0.
- One natural sub-module, `rf_read_port`, instantiated twice. It performs the x0 forcing and the optional bypass mux.

## Test plan
- Reset then read x5 → busy 0, value 0.
- Launch x5 tag 3; next cycle read x5 → busy 1, tag 3. Commit x5 tag 3 value 0xDEADBEEF; next cycle → busy 0, value 0xDEADBEEF.
- Launch x7 tag 2, then launch x7 tag 9, then commit x7 tag 2 value 0x11 → value 0x11, busy 1, tag 9.
- Same-cycle launch x4 tag 6 and commit x4 tag 1 value 0x22 → value 0x22, busy 1, tag 6.
- Launch x1–x3 busy; assert `_clear` together with launch x8 tag 4 and commit x2 value 0x33 → all busy 0, x8 not busy, x2=0x33.
- Launch x0, commit x0 value 5, and drop `rdy_in` during a launch of x9 → x0 reads 0 and not busy, x9 not busy.
- With `REGFILE_COMMIT_BYPASS_EN` defined, read x5 in the same cycle as its matching commit → busy 0 and the commit value returned immediately.
